program_loader: RTL

Boot-time program loader sitting directly upstream of the single-cycle core and its instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into the instruction memory's write port. It holds the core in reset until the whole image has been committed, then releases it. This replaces file-based ROM preloading so that benches and hardware load programs the same way.

---
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader.sv | 124 ++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader is the slave side; the stream source and memory are the master side.
interface program_loader_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int SIZE       = 32
);
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  rx_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [SIZE-1:0]       imem_wdata;

   modport master (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/program_loader.sv
// Boot loader: reads a count-prefixed little-endian byte stream, writes 32-bit words
// into instruction memory and holds the core in reset until the image is complete.
module program_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int SIZE       = 32
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   program_loader_if.slave    bus,
   output logic               o_core_reset_n,
   output logic               o_done,
   output logic               o_error,
   output logic [15:0]        o_words_loaded
);
   localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, FLUSH, DONE, ERROR} state_t;

   state_t                r_state;
   logic                  r_rx_ready;
   logic                  r_imem_we;
   logic [ADDR_WIDTH-1:0] r_imem_addr;
   logic [SIZE-1:0]       r_imem_wdata;
   logic                  r_core_reset_n;
   logic                  r_done;
   logic                  r_error;
   logic [15:0]           r_words_loaded;
   logic [15:0]           r_count;
   logic [1:0]            r_byte_idx;
   logic [23:0]           r_asm;

   logic                  w_xfer;
   logic [15:0]           w_count_full;
   logic                  w_last_word;

   assign w_xfer       = bus.rx_valid && r_rx_ready;
   assign w_count_full = {bus.rx_data, r_count[7:0]};
   assign w_last_word  = (r_words_loaded == r_count - 16'd1);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state        <= CNT_LO;
         r_rx_ready     <= 1'b0;
         r_imem_we      <= 1'b0;
         r_imem_addr    <= '0;
         r_imem_wdata   <= '0;
         r_core_reset_n <= 1'b0;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
         r_words_loaded <= '0;
         r_count        <= '0;
         r_byte_idx     <= '0;
         r_asm          <= '0;
      end else begin
         r_imem_we <= 1'b0;
         case (r_state)
            CNT_LO: begin
               r_rx_ready <= 1'b1;
               if (w_xfer) begin
                  r_count[7:0] <= bus.rx_data;
                  r_state      <= CNT_HI;
               end
            end
            CNT_HI: begin
               if (w_xfer) begin
                  r_count <= w_count_full;
                  if (w_count_full == 16'd0) begin
                     r_state        <= DONE;
                     r_rx_ready     <= 1'b0;
                     r_done         <= 1'b1;
                     r_core_reset_n <= 1'b1;
                  end else if (32'(w_count_full) > DEPTH) begin
                     r_state    <= ERROR;
                     r_rx_ready <= 1'b0;
                     r_error    <= 1'b1;
                  end else begin
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               if (w_xfer) begin
                  // Bytes 0..2 shift down so byte 0 ends up in bits 7:0 when byte 3 arrives.
                  r_asm      <= {bus.rx_data, r_asm[23:8]};
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     r_imem_we      <= 1'b1;
                     r_imem_addr    <= r_words_loaded[ADDR_WIDTH-1:0];
                     r_imem_wdata   <= {bus.rx_data, r_asm};
                     r_words_loaded <= r_words_loaded + 16'd1;
                     if (w_last_word) begin
                        r_state    <= FLUSH;
                        r_rx_ready <= 1'b0;
                     end
                  end
               end
            end
            FLUSH: begin
               r_state        <= DONE;
               r_done         <= 1'b1;
               r_core_reset_n <= 1'b1;
            end
            DONE: begin
               r_rx_ready <= 1'b0;
            end
            ERROR: begin
               r_rx_ready <= 1'b0;
            end
            default: begin
               r_state <= CNT_LO;
            end
         endcase
      end
   end

   assign bus.rx_ready    = r_rx_ready;
   assign bus.imem_we     = r_imem_we;
   assign bus.imem_addr   = r_imem_addr;
   assign bus.imem_wdata  = r_imem_wdata;
   assign o_core_reset_n  = r_core_reset_n;
   assign o_done          = r_done;
   assign o_error         = r_error;
   assign o_words_loaded  = r_words_loaded;
endmodule
